// File: rtl/count_up_to_limit.sv
// count_up_to_limit: two-digit BCD up-counter that stops at a reconfigurable limit
// Ports:
//   clk            - single clock, all state on the rising edge
//   reset          - asynchronous active-low reset
//   reconfig       - latch limit, clear count, start counting (beats increment)
//   setLimit_tens  - BCD tens digit of the limit (values >9 clamp to 9)
//   setLimit_units - BCD units digit of the limit (values >9 clamp to 9)
//   increment      - one count event per cycle held high
//   digit_tens     - BCD tens of the current count
//   digit_units    - BCD units of the current count
//   busy           - high while counting
//   count_done     - high once the count equals the limit
// Macro COUNT_UP_AUTO_TICK_EN: ignore increment and count on an internal
// prescaler that fires once every TICK_DIV cycles spent counting.
module count_up_to_limit #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reconfig,
    input  logic [3:0] setLimit_tens,
    input  logic [3:0] setLimit_units,
    input  logic       increment,
    output logic [3:0] digit_tens,
    output logic [3:0] digit_units,
    output logic       busy,
    output logic       count_done
);
    typedef enum logic [1:0] {IDLE, COUNTING, DONE} state_t;
    state_t     state_q;
    logic [3:0] tens_q, units_q, lim_tens_q, lim_units_q;
    logic [3:0] tens_d, units_d, set_tens, set_units;
    logic       busy_q, done_q, ev, set_zero;
`ifdef COUNT_UP_AUTO_TICK_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [PW-1:0] presc_q;
    logic          unused_increment;
    assign unused_increment = increment;
    assign ev = (presc_q == PW'(TICK_DIV - 1));
    // Prescaler only advances while counting and restarts on every reconfig
    always_ff @(posedge clk or negedge reset)
        if (!reset) presc_q <= '0;
        else if (reconfig || (state_q == COUNTING && ev)) presc_q <= '0;
        else if (state_q == COUNTING) presc_q <= presc_q + 1'b1;
`else
    localparam int unused_tick_div = TICK_DIV;
    assign ev = increment;
`endif
    always_comb begin
        set_tens  = (setLimit_tens > 4'd9) ? 4'd9 : setLimit_tens;
        set_units = (setLimit_units > 4'd9) ? 4'd9 : setLimit_units;
        set_zero  = (set_tens == 4'd0) && (set_units == 4'd0);
        // Count stays below the limit while counting, so the tens carry never leaves BCD
        units_d   = (units_q == 4'd9) ? 4'd0 : units_q + 4'd1;
        tens_d    = (units_q == 4'd9) ? tens_q + 4'd1 : tens_q;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q     <= IDLE;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            lim_tens_q  <= 4'd0;
            lim_units_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (reconfig) begin
            lim_tens_q  <= set_tens;
            lim_units_q <= set_units;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            state_q     <= set_zero ? DONE : COUNTING;
            busy_q      <= !set_zero;
            done_q      <= set_zero;
        end else if (state_q == COUNTING && ev) begin
            tens_q  <= tens_d;
            units_q <= units_d;
            if (tens_d == lim_tens_q && units_d == lim_units_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    assign digit_tens  = tens_q;
    assign digit_units = units_q;
    assign busy        = busy_q;
    assign count_done  = done_q;
endmodule

// File: doc/count_up_to_limit.md
COUNT_UP_TO_LIMIT -- requirements
Module: count_up_to_limit

Interface
REQ-001 SHALL have parameter: TICK_DIV, default 50000000, internal tick period in clk cycles (used only with COUNT_UP_AUTO_TICK_EN).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: reconfig  input  1  level-sampled; load limit, clear count, start counting.
REQ-005 SHALL have port: setLimit_tens  input  4  BCD tens digit of limit.
REQ-006 SHALL have port: setLimit_units  input  4  BCD units digit of limit.
REQ-007 SHALL have port: increment  input  1  one-cycle count request.
REQ-008 SHALL have port: digit_tens  output  4  BCD tens of current count.
REQ-009 SHALL have port: digit_units  output  4  BCD units of current count.
REQ-010 SHALL have port: busy  output  1  high in COUNTING.
REQ-011 SHALL have port: count_done  output  1  high in DONE (count equals limit).

Function
REQ-012 SHALL implement states IDLE, COUNTING, DONE; all outputs registered.
REQ-013 SHALL, in any state, on an edge with reconfig=1: latch limit, set count to 00, go to COUNTING; if latched limit is 00, go to DONE instead.
REQ-014 SHALL clamp any limit digit >9 to 9 at latch time.
REQ-015 SHALL give reconfig priority over increment in the same cycle (increment dropped).
REQ-016 SHALL, in COUNTING, on an edge with an increment event: units+1; units 9 -> 0 with tens+1.
REQ-017 SHALL, on the edge that loads a count equal to the latched limit, enter DONE (count_done=1, busy=0 from that edge).
REQ-018 SHALL ignore increment in IDLE and DONE; count holds.
REQ-019 SHALL never exceed 99 nor produce a non-BCD digit.
REQ-020 SHALL have a latency of 1 cycle from sampled increment to updated digit outputs.
REQ-021 SHALL treat increment held high N cycles as N events.

Reset
REQ-022 SHALL, on reset low (any time, including mid-count), immediately force IDLE, digits 00, limit 00, busy=0, count_done=0, prescaler 0.
REQ-023 SHALL resume operation only on a reconfig after reset deasserts.

Configuration
REQ-024 SHALL support macro COUNT_UP_AUTO_TICK_EN.
REQ-025 SHALL, when COUNT_UP_AUTO_TICK_EN is defined: ignore the increment port; generate increment events from an internal prescaler.
  - prescaler counts 0..TICK_DIV-1 only in COUNTING
  - one event when the prescaler is at TICK_DIV-1, then wraps to 0
  - prescaler cleared on reconfig
REQ-026 SHALL, when COUNT_UP_AUTO_TICK_EN is undefined: use the increment port as the event source and include no prescaler logic.

Verification
REQ-027 SHALL cover: reconfig, limit 12, 12 increment pulses -> digits go 00..09,10,11,12; count_done=1 on the 12th update edge; busy=0 from then.
REQ-028 SHALL cover: limit 05 reached, then 3 more increments -> digits stay 05, count_done stays 1.
REQ-029 SHALL cover: reconfig and increment asserted in the same cycle with limit 30 -> digits 00, busy=1.
REQ-030 SHALL cover: limit 00 -> next cycle count_done=1, busy=0, digits 00.
REQ-031 SHALL cover: reset pulsed low at count 07 between clock edges -> outputs 00/0/0 without a clock edge; increments then ignored until reconfig.
REQ-032 SHALL cover: COUNT_UP_AUTO_TICK_EN defined, TICK_DIV=4, limit 02, increment held 0 -> units increments every 4 cycles; count_done=1 8 cycles after reconfig edge.
